mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported, fixed-latency unified memory between instruction fetch (IF) and the
//  MEM-stage data access. Grants one access at a time via a small FSM and counts the memory latency.
//  Returns read data with a one-cycle ack, and drives stall_if/stall_mem into the hazard unit so
//  that the pipeline holds while its access is pending.
// PARAMETERS
//  MEM_LATENCY   2   cycles from issue edge to mem_rdata valid (>=1)
//  STARVE_LIMIT  4   consecutive data grants allowed while if_req waits (only with STARVE_GUARD_EN)
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-low reset
//  if_req     in   1   fetch request, held until if_ack
//  if_addr    in   32  fetch byte address
//  if_rdata   out  32  fetch data, valid when if_ack
//  if_ack     out  1   one-cycle fetch completion
//  d_req      in   1   data request, held until d_ack
//  d_we       in   1   1 = write, 0 = read
//  d_addr     in   32  data byte address
//  d_wdata    in   32  store data
//  d_rdata    out  32  load data, valid when d_ack
//  d_ack      out  1   one-cycle data completion (reads and writes)
//  mem_en     out  1   issue strobe to the memory, one cycle per access
//  mem_we     out  1   write enable, qualified by mem_en
//  mem_addr   out  32  memory address, valid with mem_en
//  mem_wdata  out  32  memory write data, valid with mem_en & mem_we
//  mem_rdata  in   32  memory read data, valid MEM_LATENCY cycles after the issue edge
//  stall_if   out  1   if_req & ~if_ack
//  stall_mem  out  1   d_req & ~d_ack
// BEHAVIOUR
//  - States: IDLE, BUSY_I, BUSY_D. The latency counter lat_cnt has width $clog2(MEM_LATENCY+1).
//  - IDLE: if d_req, issue the data access. Else if if_req, issue the fetch. Else do nothing.
//  - Issue is combinational in the IDLE cycle: mem_en=1 and mem_addr/mem_we/mem_wdata come from the
//    winner. At the clock edge the FSM goes to BUSY_x and lat_cnt loads MEM_LATENCY.
//  - BUSY_x: lat_cnt decrements each cycle. When lat_cnt==1, x_ack=1 and x_rdata=mem_rdata,
//    and the FSM returns to IDLE on the next edge.
//  - Ack timing: for a request first seen in IDLE at cycle 0, ack is asserted in cycle MEM_LATENCY.
//    Throughput is one access per MEM_LATENCY+1 cycles. A new issue is never made in an ack cycle.
//  - mem_en=0 and mem_we=0 whenever state!=IDLE. if_rdata/d_rdata are 0 when their ack is low.
//  - Writes are acked like reads. d_rdata is 0 on a write ack.
//  - Requester drops req before ack: the access still completes and the ack pulse still occurs.
//    The requester ignores it; no retry is made.
//  - Requester raises req during the other's BUSY: it waits. Its stall stays high until its own ack.
//  - Both requests present in IDLE: data wins (it is the older instruction).
//  - Reset asserted (reset==0) at any time, including mid-access: state=IDLE, lat_cnt=0,
//    starve_cnt=0, all outputs 0 (mem_en forced 0 while in reset). Any in-flight response is discarded.
//  - stall_if/stall_mem are purely combinational from the request inputs and the acks.
// CONFIGURATION
//  STARVE_GUARD_EN defined:
//    - starve_cnt counts data grants issued while if_req=1, saturating at STARVE_LIMIT.
//    - When starve_cnt==STARVE_LIMIT and both requests are present in IDLE, fetch wins and
//      starve_cnt clears.
//    - A fetch grant, or IDLE with if_req=0, also clears starve_cnt.
//  STARVE_GUARD_EN undefined:
//    - Strict data priority; no starve_cnt logic is present.
// TESTING
//  1. MEM_LATENCY=2, if_req only, addr 0x40, mem returns 0x00500093 -> mem_en in cycle 0,
//     if_ack+if_rdata=0x00500093 in cycle 2, stall_if=1 in cycles 0-1.
//  2. Both req in same cycle, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> data issued first,
//     d_ack in cycle 2, fetch issued in cycle 3, if_ack in cycle 5.
//  3. Back-to-back d_req, 3 loads, MEM_LATENCY=3 -> issues at cycles 0, 4, 8; acks at 3, 7, 11.
//  4. STARVE_GUARD_EN, STARVE_LIMIT=2, d_req and if_req held continuously -> grant order D, D, I, D, D, I.
//     Without the macro: D only while d_req is held.
//  5. reset driven low in cycle 1 of BUSY_D -> all outputs 0 immediately. After release: IDLE,
//     no stale ack, and the next request is acked after exactly MEM_LATENCY cycles.
//  6. if_req dropped in cycle 1 of BUSY_I -> if_ack still pulses in cycle MEM_LATENCY, then IDLE
//     with mem_en=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: grants one access at a time to a single-ported, fixed-latency
// unified memory, shared by instruction fetch and the MEM-stage data port.
// Optional build macro STARVE_GUARD_EN adds a fetch anti-starvation counter;
// without it data always wins a simultaneous request.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  localparam int unsigned   LW       = $clog2(MEM_LATENCY + 1);
  localparam logic [LW-1:0] LAT_LOAD = LW'(MEM_LATENCY);
  localparam logic [LW-1:0] LAT_LAST = LW'(1);

  if (MEM_LATENCY == 0 || STARVE_LIMIT == 0) begin : g_param_check
    $error("mem_port_arbiter: MEM_LATENCY and STARVE_LIMIT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic          we_q, we_d;       // in-flight data access is a write
  logic          grant_i, grant_d;
  logic          ack_i, ack_d;
  logic          fetch_first;      // fetch overrides data priority this cycle

`ifdef STARVE_GUARD_EN
  localparam int unsigned   SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt_q, starve_cnt_d;

  assign fetch_first = (starve_cnt_q == STARVE_MAX);

  // Count data grants made while fetch waits; clear once fetch wins or stops asking
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (state_q == IDLE) begin
      if (!if_req || grant_i) begin
        starve_cnt_d = '0;
      end else if (grant_d && (starve_cnt_q != STARVE_MAX)) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end
`else
  assign fetch_first = 1'b0;
`endif

  // Arbitration, issue and latency countdown
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    we_d      = we_q;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    ack_i     = 1'b0;
    ack_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (d_req && !(if_req && fetch_first)) grant_d = 1'b1;
        else if (if_req)                       grant_i = 1'b1;
        if (grant_d) begin
          state_d   = BUSY_D;
          lat_cnt_d = LAT_LOAD;
          we_d      = d_we;
        end else if (grant_i) begin
          state_d   = BUSY_I;
          lat_cnt_d = LAT_LOAD;
        end
      end
      BUSY_I, BUSY_D: begin
        lat_cnt_d = lat_cnt_q - 1'b1;
        if (lat_cnt_q == LAT_LAST) begin
          ack_i   = (state_q == BUSY_I);
          ack_d   = (state_q == BUSY_D);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latency counter and write flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      we_q      <= we_d;
    end
  end

  // Issue side is gated by reset so nothing reaches memory while held in reset
  assign mem_en    = reset & (grant_i | grant_d);
  assign mem_we    = reset & grant_d & d_we;
  assign mem_addr  = !reset ? '0 : grant_d ? d_addr : grant_i ? if_addr : '0;
  assign mem_wdata = (reset & grant_d & d_we) ? d_wdata : '0;

  assign if_ack    = ack_i;
  assign d_ack     = ack_d;
  assign if_rdata  = ack_i ? mem_rdata : '0;
  assign d_rdata   = (ack_d && !we_q) ? mem_rdata : '0;

  assign stall_if  = reset & if_req & ~ack_i;
  assign stall_mem = reset & d_req & ~ack_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: scoreboard of expected acks (kind, data, cycle)
// checked by per-instance monitors on the falling edge; directed stimulus.
module tb_mem_port_arbiter;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  exp_t q2[$];
  exp_t q3[$];

  // Instance A: MEM_LATENCY=2, STARVE_LIMIT=2
  logic        reset, if_req, if_ack, d_req, d_we, d_ack, mem_en, mem_we, stall_if, stall_mem;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(2)) u_a (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  // Instance B: MEM_LATENCY=3, data port only
  logic        b_reset, b_if_req, b_if_ack, b_d_req, b_d_we, b_d_ack, b_mem_en, b_mem_we;
  logic        b_stall_if, b_stall_mem;
  logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_port_arbiter #(.MEM_LATENCY(3)) u_b (
    .clk(clk), .reset(b_reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_ack(b_d_ack),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .stall_if(b_stall_if), .stall_mem(b_stall_mem)
  );

  // Memory models: unwritten words read back as {addr[15:0], 16'hC0DE}
  logic [31:0] mem2 [logic [31:0]];
  logic [31:0] p2 [1:2];
  logic [31:0] p3 [1:3];
  logic [31:0] r2, r3;

  function automatic logic [31:0] pat(logic [31:0] a);
    return {a[15:0], 16'hC0DE};
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) mem2[mem_addr] = mem_wdata;
    r2 = (mem_en && !mem_we) ? (mem2.exists(mem_addr) ? mem2[mem_addr] : pat(mem_addr)) : 32'h0;
    p2[1] <= r2;
    p2[2] <= p2[1];
    r3 = (b_mem_en && !b_mem_we) ? pat(b_mem_addr) : 32'h0;
    p3[1] <= r3;
    p3[2] <= p3[1];
    p3[3] <= p3[2];
  end
  assign mem_rdata   = p2[2];
  assign b_mem_rdata = p3[3];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor A: acks, read data and stalls against the scoreboard
  bit ea_i, ea_d;
  always @(negedge clk) begin
    ea_i = 1'b0;
    ea_d = 1'b0;
    if (q2.size() > 0 && q2[0].cyc == cyc) begin
      if (q2[0].is_d) ea_d = 1'b1;
      else            ea_i = 1'b1;
    end
    chk("a_if_ack", {31'b0, if_ack}, {31'b0, ea_i});
    chk("a_d_ack",  {31'b0, d_ack},  {31'b0, ea_d});
    chk("a_if_rdata", if_rdata, ea_i ? q2[0].data : 32'h0);
    chk("a_d_rdata",  d_rdata,  ea_d ? q2[0].data : 32'h0);
    chk("a_stall_if",  {31'b0, stall_if},  {31'b0, reset & if_req & ~ea_i});
    chk("a_stall_mem", {31'b0, stall_mem}, {31'b0, reset & d_req & ~ea_d});
    if (ea_i || ea_d) void'(q2.pop_front());
  end

  // Monitor B
  bit eb_d;
  always @(negedge clk) begin
    eb_d = (q3.size() > 0 && q3[0].cyc == cyc);
    chk("b_d_ack",  {31'b0, b_d_ack}, {31'b0, eb_d});
    chk("b_if_ack", {31'b0, b_if_ack}, 32'h0);
    chk("b_d_rdata", b_d_rdata, eb_d ? q3[0].data : 32'h0);
    chk("b_stall_mem", {31'b0, b_stall_mem}, {31'b0, b_reset & b_d_req & ~eb_d});
    if (eb_d) void'(q3.pop_front());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push2(bit is_d, logic [31:0] data, int c);
    exp_t e;
    e.is_d = is_d; e.data = data; e.cyc = c;
    q2.push_back(e);
  endtask

  task automatic push3(logic [31:0] data, int c);
    exp_t e;
    e.is_d = 1'b1; e.data = data; e.cyc = c;
    q3.push_back(e);
  endtask

  task automatic wait_d_ack();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (d_ack) break;
    end
    chk("a_d_ack_wait", {31'b0, d_ack}, 32'h1);
    #1;
  endtask

  task automatic run_d(bit we, logic [31:0] addr, logic [31:0] wdata);
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    wait_d_ack();
    d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic run_i(logic [31:0] addr);
    if_req = 1'b1; if_addr = addr;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if_ack) break;
    end
    chk("a_if_ack_wait", {31'b0, if_ack}, 32'h1);
    #1;
    if_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int c0;
  logic [31:0] seq_addr [0:3];

  initial begin
    reset = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0;
    b_reset = 1'b0; b_if_req = 1'b0; b_if_addr = '0; b_d_req = 1'b0; b_d_we = 1'b0;
    b_d_addr = '0; b_d_wdata = '0;
    p2[1] = '0; p2[2] = '0; p3[1] = '0; p3[2] = '0; p3[3] = '0;
    mem2[32'h40] = 32'h00500093;
    seq_addr[0] = 32'h300; seq_addr[1] = 32'h304; seq_addr[2] = 32'h308; seq_addr[3] = 32'h30C;

    // Held in reset with a request present: nothing issues
    tick();
    d_req = 1'b1; d_addr = 32'h80;
    #1;
    chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    tick();
    d_req = 1'b0;
    tick();
    reset = 1'b1; b_reset = 1'b1;
    tick(); tick();

    // 1: fetch only
    tick();
    c0 = cyc;
    push2(1'b0, 32'h00500093, c0 + 2);
    fork
      run_i(32'h40);
      begin
        #1;
        chk("t1_mem_en", {31'b0, mem_en}, 32'h1);
        chk("t1_mem_addr", mem_addr, 32'h40);
        chk("t1_mem_we", {31'b0, mem_we}, 32'h0);
      end
    join
    tick();
    chk("t1_idle_mem_en", {31'b0, mem_en}, 32'h0);

    // 2: simultaneous write and fetch, data first
    tick();
    c0 = cyc;
    push2(1'b1, 32'h0, c0 + 2);
    push2(1'b0, 32'h0044C0DE, c0 + 5);
    fork
      run_d(1'b1, 32'h100, 32'hDEADBEEF);
      run_i(32'h44);
      begin
        #1;
        chk("t2_mem_we", {31'b0, mem_we}, 32'h1);
        chk("t2_mem_addr", mem_addr, 32'h100);
        chk("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
        tick();
        chk("t2_busy_mem_en", {31'b0, mem_en}, 32'h0);
        tick();
        chk("t2_ack_mem_en", {31'b0, mem_en}, 32'h0);
        tick();
        chk("t2_fetch_mem_en", {31'b0, mem_en}, 32'h1);
        chk("t2_fetch_addr", mem_addr, 32'h44);
      end
    join

    // Read back the stored word
    tick();
    c0 = cyc;
    push2(1'b1, 32'hDEADBEEF, c0 + 2);
    run_d(1'b0, 32'h100, 32'h0);

    // 4: data held for four loads while fetch waits
    tick();
    c0 = cyc;
`ifdef STARVE_GUARD_EN
    push2(1'b1, 32'h0300C0DE, c0 + 2);
    push2(1'b1, 32'h0304C0DE, c0 + 5);
    push2(1'b0, 32'h0048C0DE, c0 + 8);
    push2(1'b1, 32'h0308C0DE, c0 + 11);
    push2(1'b1, 32'h030CC0DE, c0 + 14);
`else
    push2(1'b1, 32'h0300C0DE, c0 + 2);
    push2(1'b1, 32'h0304C0DE, c0 + 5);
    push2(1'b1, 32'h0308C0DE, c0 + 8);
    push2(1'b1, 32'h030CC0DE, c0 + 11);
    push2(1'b0, 32'h0048C0DE, c0 + 14);
`endif
    fork
      begin
        d_req = 1'b1; d_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
          d_addr = seq_addr[k];
          wait_d_ack();
        end
        d_req = 1'b0;
      end
      run_i(32'h48);
    join

    // 5: reset during the first BUSY_D cycle
    tick();
    c0 = cyc;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h308;
    tick();
    reset = 1'b0; d_req = 1'b0;
    #1;
    chk("t5_mem_en", {31'b0, mem_en}, 32'h0);
    chk("t5_mem_we", {31'b0, mem_we}, 32'h0);
    chk("t5_mem_addr", mem_addr, 32'h0);
    chk("t5_mem_wdata", mem_wdata, 32'h0);
    chk("t5_d_ack", {31'b0, d_ack}, 32'h0);
    chk("t5_d_rdata", d_rdata, 32'h0);
    tick(); tick();
    reset = 1'b1;
    tick(); tick(); tick();
    c0 = cyc;
    push2(1'b1, 32'h030CC0DE, c0 + 2);
    run_d(1'b0, 32'h30C, 32'h0);

    // 6: fetch dropped during BUSY_I still completes
    tick();
    c0 = cyc;
    push2(1'b0, 32'h00500093, c0 + 2);
    if_req = 1'b1; if_addr = 32'h40;
    tick();
    if_req = 1'b0;
    tick();
    tick();
    chk("t6_idle_mem_en", {31'b0, mem_en}, 32'h0);
    tick();

    // 3: three back-to-back loads at MEM_LATENCY=3
    tick();
    c0 = cyc;
    push3(32'h0200C0DE, c0 + 3);
    push3(32'h0204C0DE, c0 + 7);
    push3(32'h0208C0DE, c0 + 11);
    fork
      begin
        b_d_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
          b_d_addr = 32'h200 + 32'(4 * k);
          for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (b_d_ack) break;
          end
          chk("b_d_ack_wait", {31'b0, b_d_ack}, 32'h1);
          #1;
        end
        b_d_req = 1'b0;
      end
      begin
        #1;
        chk("t3_issue0", {31'b0, b_mem_en}, 32'h1);
        repeat (3) tick();
        chk("t3_ack_no_issue", {31'b0, b_mem_en}, 32'h0);
        tick();
        chk("t3_issue1", {31'b0, b_mem_en}, 32'h1);
        chk("t3_issue1_addr", b_mem_addr, 32'h204);
        repeat (4) tick();
        chk("t3_issue2_addr", b_mem_addr, 32'h208);
      end
    join

    repeat (4) tick();
    chk("q2_drained", q2.size(), 32'h0);
    chk("q3_drained", q3.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
